// File: rtl/fp_alu_pkg.sv
// Shared opcodes, FSM states and float field constants for the shared FP ALU.
package fp_alu_pkg;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    localparam int         EXP_MSB = 30;
    localparam int         EXP_LSB = 23;
    localparam logic [7:0] EXP_INF = 8'hFF;
endpackage

// File: rtl/fp_alu_core.sv
// Combinational FP core: add/sub/mul/div selected by opcode, plus divide-by-zero flag.
module fp_alu_core
    import fp_alu_pkg::*;
(
    input  logic [1:0]  op_i,
    input  logic [31:0] x_i,
    input  logic [31:0] y_i,
    output logic [31:0] res_o,
    output logic        dz_o
);
    logic [31:0] y_add, add_r, mul_r, div_r;

    assign y_add = {y_i[31] ^ (op_i == OP_SUB), y_i[30:0]};

    fp_add u_add (.a_i(x_i), .b_i(y_add), .s_o(add_r));
    fp_mul u_mul (.a_i(x_i), .b_i(y_i),   .p_o(mul_r));
    fp_div u_div (.a_i(x_i), .b_i(y_i),   .q_o(div_r));

    always_comb begin
        case (op_i)
            OP_MUL:  res_o = mul_r;
            OP_DIV:  res_o = div_r;
            default: res_o = add_r;
        endcase
    end

    assign dz_o = (op_i == OP_DIV) && (y_i[30:0] == 31'd0);
endmodule

// File: rtl/fp_alu_units.sv
// Combinational single-precision add, multiply and divide units (truncating,
// subnormals flushed to zero).
module fp_add
    import fp_alu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] s_o
);
    logic [31:0] big, sml;
    logic [27:0] mb, ms, sum;
    logic [7:0]  e, d;

    always_comb begin
        big = a_i;
        sml = b_i;
        if (b_i[30:0] > a_i[30:0]) begin
            big = b_i;
            sml = a_i;
        end
        // [27] carry, [26] hidden bit, [25:3] fraction, [2:0] alignment guard
        mb  = {1'b0, big[EXP_MSB:EXP_LSB] != 8'd0, big[22:0], 3'b0};
        ms  = {1'b0, sml[EXP_MSB:EXP_LSB] != 8'd0, sml[22:0], 3'b0};
        d   = big[EXP_MSB:EXP_LSB] - sml[EXP_MSB:EXP_LSB];
        ms  = (d > 8'd27) ? 28'd0 : (ms >> d);
        sum = (big[31] == sml[31]) ? (mb + ms) : (mb - ms);
        e   = big[EXP_MSB:EXP_LSB];
        if (sum[27]) begin
            sum = sum >> 1;
            e   = e + 8'd1;
        end else begin
            for (int i = 0; i < 26; i++) begin
                if (!sum[26]) begin
                    sum = sum << 1;
                    e   = e - 8'd1;
                end
            end
        end
        s_o = {big[31], e, sum[25:3]};
        // exact cancellation or zero operands always yield +0
        if (sum == 28'd0 || big[EXP_MSB:EXP_LSB] == 8'd0) s_o = 32'd0;
    end
endmodule

module fp_mul
    import fp_alu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] p_o
);
    logic [23:0] ma, mb;
    logic [47:0] p;
    logic [7:0]  e;
    logic        unused_lo;

    assign ma        = {1'b1, a_i[22:0]};
    assign mb        = {1'b1, b_i[22:0]};
    assign p         = {24'd0, ma} * {24'd0, mb};
    assign e         = a_i[EXP_MSB:EXP_LSB] + b_i[EXP_MSB:EXP_LSB] - 8'd127 + {7'd0, p[47]};
    assign unused_lo = ^p[22:0];

    always_comb begin
        p_o = {a_i[31] ^ b_i[31], e, p[47] ? p[46:24] : p[45:23]};
        if (a_i[EXP_MSB:EXP_LSB] == 8'd0 || b_i[EXP_MSB:EXP_LSB] == 8'd0) p_o = 32'd0;
    end
endmodule

module fp_div
    import fp_alu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] q_o
);
    logic [23:0] ma, mb;
    logic [47:0] q;
    logic [7:0]  e;
    logic        unused_hi;

    assign ma        = {1'b1, a_i[22:0]};
    assign mb        = {1'b1, b_i[22:0]};
    assign q         = {ma, 24'd0} / {24'd0, mb};
    assign e         = a_i[EXP_MSB:EXP_LSB] - b_i[EXP_MSB:EXP_LSB] + 8'd126 + {7'd0, q[24]};
    assign unused_hi = ^q[47:25];

    always_comb begin
        q_o = {a_i[31] ^ b_i[31], e, q[24] ? q[23:1] : q[22:0]};
        if (b_i[EXP_MSB:EXP_LSB] == 8'd0)      q_o = {a_i[31] ^ b_i[31], EXP_INF, 23'd0};
        else if (a_i[EXP_MSB:EXP_LSB] == 8'd0) q_o = 32'd0;
    end
endmodule

// File: rtl/fp_alu_arbiter.sv
// Round-robin arbiter sharing one multicycle FP core between two valid/ready requesters.
module fp_alu_arbiter
    import fp_alu_pkg::*;
#(
    parameter int ADD_CYC = 1,
    parameter int MUL_CYC = 2,
    parameter int DIV_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [3:0]  req_op,
    input  logic [63:0] req_x,
    input  logic [63:0] req_y,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_dz,
    output logic        busy
);
    state_e      state_q, state_d;
    logic        last_q, last_d, gnt_id;
    logic [1:0]  op_q, op_d;
    logic [31:0] x_q, x_d, y_q, y_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d, rsp_dz_q, rsp_dz_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [31:0] core_res;
    logic        core_dz;

    function automatic logic [7:0] lat_m1(input logic [1:0] op);
        case (op)
            OP_MUL:  return 8'(MUL_CYC - 1);
            OP_DIV:  return 8'(DIV_CYC - 1);
            default: return 8'(ADD_CYC - 1);
        endcase
    endfunction

    // Core sees only latched operands, so its paths span the whole EXEC window.
    fp_alu_core u_core (.op_i(op_q), .x_i(x_q), .y_i(y_q), .res_o(core_res), .dz_o(core_dz));

    assign gnt_id = (req_valid == 2'b11) ? ~last_q : req_valid[1];

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        op_d        = op_q;
        x_d         = x_q;
        y_d         = y_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_dz_d    = rsp_dz_q;
        req_ready   = 2'b00;
        case (state_q)
            IDLE: if (|req_valid) begin
                req_ready = gnt_id ? 2'b10 : 2'b01;
                op_d      = gnt_id ? req_op[3:2]  : req_op[1:0];
                x_d       = gnt_id ? req_x[63:32] : req_x[31:0];
                y_d       = gnt_id ? req_y[63:32] : req_y[31:0];
                last_d    = gnt_id;
                cnt_d     = lat_m1(op_d);
                state_d   = EXEC;
            end
            EXEC: if (cnt_q != 8'd0) begin
                cnt_d = cnt_q - 8'd1;
            end else begin
                rsp_data_d  = core_res;
                rsp_dz_d    = core_dz;
                rsp_id_d    = last_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            op_q        <= OP_ADD;
            x_q         <= 32'd0;
            y_q         <= 32'd0;
            cnt_q       <= 8'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_id_q    <= 1'b0;
            rsp_dz_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            op_q        <= op_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_dz_q    <= rsp_dz_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_dz    = rsp_dz_q;
    assign busy      = (state_q != IDLE);
endmodule
